prv_trap_ctrl: RTL
==================

PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the datapath and CSR width.
REQ-002 SHALL have parameter NUM_IRQ, default 8 (legal 1..16), meaning the interrupt channel count.
REQ-003 SHALL have parameter IRQ_EDGE, default 0 (NUM_IRQ bits), where bit i=1 makes channel i edge-triggered and 0 makes it level-triggered.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port exc_i, input, 16 bits: exception requests; bit index is the cause code.
REQ-007 SHALL have port epc_i, input, XLEN bits: PC to save on trap entry.
REQ-008 SHALL have port tval_i, input, XLEN bits: faulting address/instruction for mtval.
REQ-009 SHALL have port irq_i, input, NUM_IRQ bits: interrupt lines.
REQ-010 SHALL have port mret_i, input, 1 bit: mret retiring.
REQ-011 SHALL have port pipe_ack_i, input, 1 bit: pipeline accepted the redirect.
REQ-012 SHALL have port csr_we_i, input, 1 bit: CSR write strobe.
REQ-013 SHALL have port csr_addr_i, input, 12 bits: CSR address.
REQ-014 SHALL have port csr_wdata_i, input, XLEN bits: CSR write data.
REQ-015 SHALL have port csr_rdata_o, output, XLEN bits: combinational read data.
REQ-016 SHALL have port csr_invalid_o, output, 1 bit: csr_addr_i is not implemented here.
REQ-017 SHALL have port insert_pc_o, output, 1 bit: redirect request.
REQ-018 SHALL have port priv_pc_o, output, XLEN bits: redirect target.
REQ-019 SHALL have port intr_o, output, 1 bit: the current redirect is an interrupt trap.
REQ-020 SHALL have port busy_o, output, 1 bit: FSM not in IDLE.

Function
REQ-021 SHALL implement the following CSRs, all other addresses giving rdata=0 and csr_invalid_o=1: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304 (low NUM_IRQ bits), mtvec 0x305, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mtval 0x343, mip 0x344 (low NUM_IRQ bits).
REQ-022 SHALL set mip[i] each cycle to irq_i[i] for a level channel; writes to that bit SHALL be ignored.
REQ-023 SHALL set mip[i] on a 0->1 transition of irq_i[i] for an edge channel, and clear it on a CSR write of 0 to that bit or on trap entry for channel i; a set and a clear in the same cycle SHALL leave the bit set.
REQ-024 SHALL implement the FSM states IDLE, TRAP and RET.
REQ-025 SHALL, in IDLE with exc_i != 0, select the lowest-index set bit as the cause, and on that edge load mepc=epc_i, mcause={0,code}, mtval=tval_i, MPIE=MIE, MIE=0, and go to TRAP.
REQ-026 SHALL otherwise, in IDLE with MIE=1 and (mip&mie) != 0, select the lowest pending-enabled channel, and on that edge load mepc=epc_i, mcause={1,code}, mtval=0, MPIE=MIE, MIE=0, and go to TRAP with intr_o=1.
REQ-027 SHALL otherwise, in IDLE with mret_i=1, on that edge set MIE=MPIE, MPIE=1, and go to RET.
REQ-028 SHALL give priority exception > interrupt > mret; a losing interrupt stays pending and a losing mret is dropped.
REQ-029 SHALL, in TRAP, drive insert_pc_o=1 and priv_pc_o=base where base={mtvec[XLEN-1:2],2'b00}, or base+4*code when mtvec[1:0]=01 and the trap is an interrupt.
REQ-030 SHALL, in RET, drive insert_pc_o=1 and priv_pc_o=mepc.
REQ-031 SHALL hold TRAP/RET and all outputs stable until pipe_ack_i=1, then return to IDLE on that edge; the minimum state length is 1 cycle.
REQ-032 SHALL ignore exc_i, mret_i and interrupt selection while in TRAP or RET.
REQ-033 SHALL, when a CSR write coincides with a trap-entry or mret update of the same register, apply the hardware update and drop the write.
REQ-034 SHALL apply CSR writes on the clock edge with no delay; reads SHALL reflect state before the edge.
REQ-035 SHALL hold insert_pc_o, intr_o and busy_o at 0 in IDLE, with priv_pc_o=0.

Reset
REQ-036 SHALL, on nRST low, asynchronously force the FSM to IDLE and clear mstatus, mie, mtvec, mepc, mcause, mtval, the edge-channel mip bits and the edge history to 0.
REQ-037 SHALL, when reset occurs mid-TRAP or mid-RET, drop insert_pc_o immediately and not resume the redirect.

Verification
REQ-038 SHALL verify: exc_i=0x0024, epc_i=0x100, tval_i=0xDEAD -> next cycle mcause=2, mepc=0x100, mtval=0xDEAD, priv_pc_o=mtvec base, MIE=0.
REQ-039 SHALL verify: mtvec=0x8001, MIE=1, mie=0xFF, edge irq_i[5] pulsed -> TRAP with intr_o=1, priv_pc_o=0x8014, mcause=0x80000005, mip[5] cleared.
REQ-040 SHALL verify: exc_i[3] and an enabled interrupt in the same cycle -> mcause=3, interrupt still pending, and it is taken after ack and mret.
REQ-041 SHALL verify: mret_i with MPIE=1, mepc=0x200 -> RET, priv_pc_o=0x200, MIE=1; with pipe_ack_i low for 3 cycles the outputs are held for 3 cycles.
REQ-042 SHALL verify: nRST asserted in TRAP -> insert_pc_o=0 asynchronously; after release all CSRs read 0 and address 0x7C0 gives csr_invalid_o=1.

Source files
------------

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap controller: CSR file, interrupt pending logic, trap/mret redirect FSM.
// Latency: trap/mret decided in IDLE, redirect presented from the next cycle; CSR reads combinational.
// Backpressure: redirect (insert_pc_o/priv_pc_o/intr_o) held stable until pipe_ack_i is sampled high.
// Ports: CLK/nRST clock and async active-low reset; exc_i/epc_i/tval_i exception request and context;
//        irq_i interrupt lines; mret_i return request; pipe_ack_i redirect accept;
//        csr_* CSR access port (read combinational, write on edge); insert_pc_o/priv_pc_o/intr_o/busy_o redirect.
module prv_trap_ctrl #(
  parameter int                 XLEN     = 32,
  parameter int                 NUM_IRQ  = 8,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [15:0]        exc_i,
  input  logic [XLEN-1:0]    epc_i,
  input  logic [XLEN-1:0]    tval_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mret_i,
  input  logic               pipe_ack_i,
  input  logic               csr_we_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               csr_invalid_o,
  output logic               insert_pc_o,
  output logic [XLEN-1:0]    priv_pc_o,
  output logic               intr_o,
  output logic               busy_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic [1:0] {IDLE = 2'd0, TRAP = 2'd1, RET = 2'd2} state_t;

  state_t state, state_nxt;

  logic               st_mie, st_mpie;
  logic [NUM_IRQ-1:0] mie_q, mip_edge_q, irq_q;
  logic [XLEN-1:0]    mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0]    pc_q;     // redirect target captured at entry so it cannot drift while waiting for ack
  logic               intr_q;

  logic [NUM_IRQ-1:0] mip, pend, irq_rise, mip_clr;
  logic [3:0]         exc_code, irq_code, trap_code;
  logic               take_exc, take_irq, take_mret, take_trap;
  logic [XLEN-1:0]    trap_base, trap_target, cause_val;
  logic               wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtval, wr_mip;

  // Level channels mirror the line directly; edge channels come from the sticky register.
  assign mip      = (IRQ_EDGE & mip_edge_q) | (~IRQ_EDGE & irq_i);
  assign pend     = mip & mie_q;
  assign irq_rise = IRQ_EDGE & irq_i & ~irq_q;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    exc_code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (exc_i[i]) exc_code = 4'(i);
    end
  end

  always_comb begin
    irq_code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_code = 4'(i);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    take_exc    = 1'b0;
    take_irq    = 1'b0;
    take_mret   = 1'b0;
    insert_pc_o = 1'b0;
    busy_o      = 1'b0;
    intr_o      = 1'b0;
    priv_pc_o   = '0;
    case (state)
      IDLE: begin
        if (|exc_i) begin
          take_exc  = 1'b1;
          state_nxt = TRAP;
        end else if (st_mie && |pend) begin
          take_irq  = 1'b1;
          state_nxt = TRAP;
        end else if (mret_i) begin
          take_mret = 1'b1;
          state_nxt = RET;
        end
      end
      TRAP, RET: begin
        insert_pc_o = 1'b1;
        busy_o      = 1'b1;
        priv_pc_o   = pc_q;
        intr_o      = (state == TRAP) && intr_q;
        if (pipe_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign take_trap   = take_exc | take_irq;
  assign trap_code   = take_exc ? exc_code : irq_code;
  assign trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = (take_irq && mtvec_q[1:0] == 2'b01) ?
                       trap_base + (XLEN'(irq_code) << 2) : trap_base;

  always_comb begin
    cause_val         = '0;
    cause_val[3:0]    = trap_code;
    cause_val[XLEN-1] = take_irq;
  end

  assign wr_mstatus = csr_we_i && csr_addr_i == ADDR_MSTATUS;
  assign wr_mie     = csr_we_i && csr_addr_i == ADDR_MIE;
  assign wr_mtvec   = csr_we_i && csr_addr_i == ADDR_MTVEC;
  assign wr_mepc    = csr_we_i && csr_addr_i == ADDR_MEPC;
  assign wr_mcause  = csr_we_i && csr_addr_i == ADDR_MCAUSE;
  assign wr_mtval   = csr_we_i && csr_addr_i == ADDR_MTVAL;
  assign wr_mip     = csr_we_i && csr_addr_i == ADDR_MIP;

  // Software can only clear edge-pending bits (write 0); taking the interrupt also clears it.
  assign mip_clr = IRQ_EDGE & ((wr_mip ? ~csr_wdata_i[NUM_IRQ-1:0] : '0) |
                               (take_irq ? (NUM_IRQ'(1) << irq_code) : '0));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mip_edge_q <= '0;
      irq_q      <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      pc_q       <= '0;
      intr_q     <= 1'b0;
    end else begin
      irq_q      <= irq_i;
      // A new rising edge beats a same-cycle clear.
      mip_edge_q <= IRQ_EDGE & ((mip_edge_q & ~mip_clr) | irq_rise);
      if (wr_mie)   mie_q   <= csr_wdata_i[NUM_IRQ-1:0];
      if (wr_mtvec) mtvec_q <= csr_wdata_i;
      if (take_trap) begin
        // Hardware update owns mstatus/mepc/mcause/mtval this edge; any CSR write to them is dropped.
        mepc_q   <= epc_i;
        mcause_q <= cause_val;
        mtval_q  <= take_exc ? tval_i : '0;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        pc_q     <= trap_target;
        intr_q   <= take_irq;
      end else begin
        if (take_mret) begin
          st_mie  <= st_mpie;
          st_mpie <= 1'b1;
          pc_q    <= {mepc_q[XLEN-1:2], 2'b00};
          intr_q  <= 1'b0;
        end else if (wr_mstatus) begin
          st_mie  <= csr_wdata_i[3];
          st_mpie <= csr_wdata_i[7];
        end
        if (wr_mepc)   mepc_q   <= csr_wdata_i;
        if (wr_mcause) mcause_q <= csr_wdata_i;
        if (wr_mtval)  mtval_q  <= csr_wdata_i;
      end
    end
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_invalid_o = 1'b0;
    case (csr_addr_i)
      ADDR_MSTATUS: begin
        csr_rdata_o[3] = st_mie;
        csr_rdata_o[7] = st_mpie;
      end
      ADDR_MIE:    csr_rdata_o[NUM_IRQ-1:0] = mie_q;
      ADDR_MTVEC:  csr_rdata_o = mtvec_q;
      ADDR_MEPC:   csr_rdata_o = {mepc_q[XLEN-1:2], 2'b00};
      ADDR_MCAUSE: csr_rdata_o = mcause_q;
      ADDR_MTVAL:  csr_rdata_o = mtval_q;
      ADDR_MIP:    csr_rdata_o[NUM_IRQ-1:0] = mip;
      default:     csr_invalid_o = 1'b1;
    endcase
  end

endmodule
